// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, baud divisor, sticky status flags,
// a three-state transmit sequencer and a registered, maskable interrupt.
module uart_ctrl #(
  parameter int          FIFO_AW    = 2,
  parameter logic [15:0] CLKDIV_RST = 16'd1302
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        irq,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  output logic [15:0] uart_clk_div,
  input  logic        uart_received,
  input  logic [7:0]  uart_rx_byte,
  input  logic        uart_is_transmitting,
  input  logic        uart_recv_error
);

  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DONE} tx_state_t;

  tx_state_t          tx_state_q;
  logic [7:0]         tx_mem_q [DEPTH];
  logic [7:0]         rx_mem_q [DEPTH];
  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               txovf_q, txovf_d, rxovr_q, rxovr_d, ferr_q, ferr_d;
  logic [2:0]         ien_q, ien_d;
  logic [15:0]        clkdiv_q, clkdiv_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               irq_q, irq_d;

  logic tx_full, tx_empty, tx_push, tx_push_ok, tx_pop;
  logic rx_full, rx_empty, rx_pop, rx_push_ok;
  logic busy;
  logic [2:0]  w1c;
  logic [15:0] status;

  function automatic logic [FIFO_AW:0] next_cnt(input logic [FIFO_AW:0] cnt,
                                                input logic push, input logic pop);
    case ({push, pop})
      2'b10:   next_cnt = cnt + CNT_ONE;
      2'b01:   next_cnt = cnt - CNT_ONE;
      default: next_cnt = cnt;
    endcase
  endfunction

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_push    = wr_en && (addr == 2'd0);
  assign tx_pop     = (tx_state_q == T_IDLE) && !tx_empty && !uart_is_transmitting;
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign rx_pop     = rd_en && (addr == 2'd0) && !rx_empty;
  assign rx_push_ok = uart_received && (!rx_full || rx_pop);

  assign busy   = !tx_empty || (tx_state_q != T_IDLE);
  assign status = {8'h00, busy, txovf_q, ferr_q, rxovr_q, tx_full, tx_empty, rx_full, !rx_empty};
  assign w1c    = (wr_en && (addr == 2'd1)) ? wr_data[6:4] : 3'b000;

  always_comb begin
    tx_wp_d   = tx_push_ok ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d   = tx_pop     ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d   = rx_push_ok ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d   = rx_pop     ? rx_rp_q + PTR_ONE : rx_rp_q;
    tx_cnt_d  = next_cnt(tx_cnt_q, tx_push_ok, tx_pop);
    rx_cnt_d  = next_cnt(rx_cnt_q, rx_push_ok, rx_pop);
    // Set events win over a same-cycle write-1-to-clear.
    rxovr_d   = (rxovr_q & ~w1c[0]) | (uart_received && rx_full && !rx_pop);
    ferr_d    = (ferr_q  & ~w1c[1]) | uart_recv_error;
    txovf_d   = (txovf_q & ~w1c[2]) | (tx_push && tx_full && !tx_pop);
    ien_d     = (wr_en && (addr == 2'd3)) ? wr_data[2:0] : ien_q;
    clkdiv_d  = (wr_en && (addr == 2'd2)) ? wr_data : clkdiv_q;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (addr)
        2'd0:    rd_data_d = rx_empty ? 16'h0000 : {8'h00, rx_mem_q[rx_rp_q]};
        2'd1:    rd_data_d = status;
        2'd2:    rd_data_d = clkdiv_q;
        default: rd_data_d = {13'h0000, ien_q};
      endcase
    end
    irq_d = (ien_q[0] & !rx_empty) | (ien_q[1] & tx_empty) |
            (ien_q[2] & (rxovr_q | ferr_q | txovf_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rxovr_q   <= 1'b0;
      ferr_q    <= 1'b0;
      txovf_q   <= 1'b0;
      ien_q     <= '0;
      clkdiv_q  <= CLKDIV_RST;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rxovr_q   <= rxovr_d;
      ferr_q    <= ferr_d;
      txovf_q   <= txovf_d;
      ien_q     <= ien_d;
      clkdiv_q  <= clkdiv_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO storage carries data only; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wp_q] <= wr_data[7:0];
    if (rx_push_ok) rx_mem_q[rx_wp_q] <= uart_rx_byte;
  end

  // T_START waits for the uart to acknowledge so one byte is never issued twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q    <= T_IDLE;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      uart_transmit <= 1'b0;
      case (tx_state_q)
        T_IDLE: begin
          if (tx_pop) begin
            uart_tx_byte  <= tx_mem_q[tx_rp_q];
            uart_transmit <= 1'b1;
            tx_state_q    <= T_START;
          end
        end
        T_START: if (uart_is_transmitting) tx_state_q <= T_DONE;
        T_DONE:  if (!uart_is_transmitting) tx_state_q <= T_IDLE;
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign irq          = irq_q;
  assign uart_clk_div = clkdiv_q;

endmodule
